// File: rtl/mash_cfg_seq_if.sv
// Register-write bus into the MASH configuration sequencer.
//   wr_en   : write strobe, at most one write per cycle
//   wr_addr : 4-bit register address
//   wr_data : 8-bit write data
// master drives the bus (host / testbench); slave is the sequencer.
interface mash_cfg_seq_if;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;

  modport master (output wr_en, output wr_addr, output wr_data);
  modport slave  (input  wr_en, input  wr_addr, input  wr_data);
endinterface

// File: rtl/mash_cfg_seq.sv
// Configuration sequencer in front of the NCSP MASH top.
// Shadow registers are filled from the write bus; a commit runs
// RESET -> SETTLE -> (PHASE) -> DONE, copying shadow to active on RESET entry.
// Ports:
//   i_clk, i_rst_n          clock, async active-low reset
//   wr_bus                  register-write bus (slave modport)
//   o_busy, o_done          sequence in progress / 1-cycle completion pulse
//   o_msb/o_isb/o_lsb/o_int active fractional and integer words
//   o_seed, o_sel_order, o_mash_bit, o_sel_frac, o_phaseadd  active settings
//   o_mash_rst, o_mashreseten  MASH reset request / reset enable (RESET state)
//   o_phaseadjusten         1-cycle phase-adjust pulse
// Optional feature macro: MASH_CFG_SEED_LFSR_EN (seed taken from a 12-bit LFSR).
module mash_cfg_seq #(
  parameter int unsigned RST_CYC    = 4,
  parameter int unsigned SETTLE_CYC = 8
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  mash_cfg_seq_if.slave       wr_bus,
  output logic                o_busy,
  output logic                o_done,
  output logic [7:0]          o_msb,
  output logic [7:0]          o_isb,
  output logic [7:0]          o_lsb,
  output logic [7:0]          o_int,
  output logic [11:0]         o_seed,
  output logic [1:0]          o_sel_order,
  output logic [3:0]          o_mash_bit,
  output logic                o_sel_frac,
  output logic [11:0]         o_phaseadd,
  output logic                o_mash_rst,
  output logic                o_mashreseten,
  output logic                o_phaseadjusten
);

  localparam int unsigned CNT_W    = 8;
  localparam int unsigned SEED_W   = 12;
  localparam logic [CNT_W-1:0] RST_LOAD    = CNT_W'(RST_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_RESET, ST_SETTLE, ST_PHASE, ST_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pend_q, pend_d;
  logic             pend_ph_q, pend_ph_d;
  logic             run_ph_q, run_ph_d;
  logic             copy_c;

  logic [7:0]        sh_msb_q, sh_isb_q, sh_lsb_q, sh_int_q;
  logic [SEED_W-1:0] sh_seed_q;
  logic [1:0]        sh_order_q;
  logic              sh_frac_q;
  logic [3:0]        sh_mbit_q;
  logic [11:0]       sh_phadd_q;
  logic [SEED_W-1:0] seed_src_c;

  logic commit_c, ph_req_c;
  assign commit_c = wr_bus.wr_en && (wr_bus.wr_addr == 4'hA) && wr_bus.wr_data[0];
  assign ph_req_c = wr_bus.wr_data[1];

  // Shadow register file, writable in any state
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sh_msb_q   <= '0;
      sh_isb_q   <= '0;
      sh_lsb_q   <= '0;
      sh_int_q   <= '0;
      sh_seed_q  <= '0;
      sh_order_q <= '0;
      sh_frac_q  <= 1'b0;
      sh_mbit_q  <= '0;
      sh_phadd_q <= '0;
    end else if (wr_bus.wr_en) begin
      case (wr_bus.wr_addr)
        4'h0: sh_msb_q          <= wr_bus.wr_data;
        4'h1: sh_isb_q          <= wr_bus.wr_data;
        4'h2: sh_lsb_q          <= wr_bus.wr_data;
        4'h3: sh_int_q          <= wr_bus.wr_data;
        4'h4: sh_seed_q[7:0]    <= wr_bus.wr_data;
        4'h5: sh_seed_q[11:8]   <= wr_bus.wr_data[3:0];
        4'h6: begin
          sh_frac_q  <= wr_bus.wr_data[2];
          sh_order_q <= wr_bus.wr_data[1:0];
        end
        4'h7: sh_mbit_q         <= wr_bus.wr_data[3:0];
        4'h8: sh_phadd_q[7:0]   <= wr_bus.wr_data;
        4'h9: sh_phadd_q[11:8]  <= wr_bus.wr_data[3:0];
        default: ;
      endcase
    end
  end

`ifdef MASH_CFG_SEED_LFSR_EN
  // Fibonacci LFSR x^12+x^6+x^4+x+1; a bus reseed wins over a step in the same cycle
  logic [SEED_W-1:0] lfsr_q;
  logic [SEED_W-1:0] reseed_val_c;
  logic              reseed_c;
  logic              lfsr_fb_c;

  assign lfsr_fb_c = lfsr_q[11] ^ lfsr_q[5] ^ lfsr_q[3] ^ lfsr_q[0];
  assign reseed_c  = wr_bus.wr_en && ((wr_bus.wr_addr == 4'h4) || (wr_bus.wr_addr == 4'h5));

  always_comb begin
    reseed_val_c = sh_seed_q;
    if (wr_bus.wr_addr == 4'h4) reseed_val_c[7:0]  = wr_bus.wr_data;
    else                        reseed_val_c[11:8] = wr_bus.wr_data[3:0];
    if (reseed_val_c == '0) reseed_val_c = SEED_W'(1);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)      lfsr_q <= SEED_W'(1);
    else if (reseed_c) lfsr_q <= reseed_val_c;
    else if (copy_c)   lfsr_q <= {lfsr_q[10:0], lfsr_fb_c};
  end

  assign seed_src_c = lfsr_q;
`else
  assign seed_src_c = sh_seed_q;
`endif

  // Sequencer state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      pend_q    <= 1'b0;
      pend_ph_q <= 1'b0;
      run_ph_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      pend_ph_q <= pend_ph_d;
      run_ph_q  <= run_ph_d;
    end
  end

  // Next-state logic; copy_c marks every entry into RESET
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    pend_ph_d = pend_ph_q;
    run_ph_d  = run_ph_q;
    copy_c    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (commit_c) begin
          state_d  = ST_RESET;
          cnt_d    = RST_LOAD;
          run_ph_d = ph_req_c;
          copy_c   = 1'b1;
        end
      end
      ST_RESET: begin
        if (cnt_q == '0) begin
          state_d = ST_SETTLE;
          cnt_d   = SETTLE_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_SETTLE: begin
        if (cnt_q == '0) state_d = run_ph_q ? ST_PHASE : ST_DONE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_PHASE: state_d = ST_DONE;
      ST_DONE: begin
        // A commit landing in DONE merges with any held one
        if (pend_q || commit_c) begin
          state_d   = ST_RESET;
          cnt_d     = RST_LOAD;
          run_ph_d  = pend_ph_q | (commit_c & ph_req_c);
          pend_d    = 1'b0;
          pend_ph_d = 1'b0;
          copy_c    = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (commit_c && (state_q != ST_IDLE) && (state_q != ST_DONE)) begin
      pend_d    = 1'b1;
      pend_ph_d = pend_ph_q | ph_req_c;
    end
  end

  // Registered control outputs decoded from the next state
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_busy          <= 1'b0;
      o_done          <= 1'b0;
      o_mash_rst      <= 1'b0;
      o_mashreseten   <= 1'b0;
      o_phaseadjusten <= 1'b0;
    end else begin
      o_busy          <= (state_d != ST_IDLE);
      o_done          <= (state_d == ST_DONE);
      o_mash_rst      <= (state_d == ST_RESET);
      o_mashreseten   <= (state_d == ST_RESET);
      o_phaseadjusten <= (state_d == ST_PHASE);
    end
  end

  // Active settings change only on RESET entry
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_msb       <= '0;
      o_isb       <= '0;
      o_lsb       <= '0;
      o_int       <= '0;
      o_seed      <= '0;
      o_sel_order <= '0;
      o_mash_bit  <= '0;
      o_sel_frac  <= 1'b0;
      o_phaseadd  <= '0;
    end else if (copy_c) begin
      o_msb       <= sh_msb_q;
      o_isb       <= sh_isb_q;
      o_lsb       <= sh_lsb_q;
      o_int       <= sh_int_q;
      o_seed      <= seed_src_c;
      o_sel_order <= sh_order_q;
      o_mash_bit  <= sh_mbit_q;
      o_sel_frac  <= sh_frac_q;
      o_phaseadd  <= sh_phadd_q;
    end
  end

endmodule
